// File: rtl/pc_flag_unit_if.sv
// Command/status bundle between the multicycle controller side and pc_flag_unit.
// The slave modport is the PC/flag stage; the master modport is whoever drives the strobes.
interface pc_flag_unit_if #(
    parameter int WIDTH = 16
);
    logic             pcAdd;
    logic             pcJump;
    logic             pcBranch;
    logic [3:0]       flagOp;
    logic [WIDTH-1:0] immediate;
    logic [WIDTH-1:0] jumpTarget;
    logic             flagWrite;
    logic [4:0]       aluFlags;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcLink;
    logic [4:0]       flags;
    logic             condMet;
    logic             redirect;
    logic [15:0]      takenCount;

    modport master (
        output pcAdd, pcJump, pcBranch, flagOp, immediate, jumpTarget, flagWrite, aluFlags,
        input  pc, pcLink, flags, condMet, redirect, takenCount
    );

    modport slave (
        input  pcAdd, pcJump, pcBranch, flagOp, immediate, jumpTarget, flagWrite, aluFlags,
        output pc, pcLink, flags, condMet, redirect, takenCount
    );
endinterface

// File: rtl/pc_flag_unit.sv
// PC register, {N,Z,F,L,C} flag register and jump/branch condition evaluation.
// Latency: pc/flags/redirect update one edge after the strobe; pcLink and condMet are combinational.
// Backpressure: none; strobes are level-sampled every edge. PC_TAKEN_COUNT_EN adds a taken counter.
module pc_flag_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    pc_flag_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_pc;
    logic [4:0]       r_flags;
    logic             r_redirect;

    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_cond;
    logic             w_taken;
    logic             w_n, w_z, w_f, w_l, w_c;

    assign w_n = r_flags[4];
    assign w_z = r_flags[3];
    assign w_f = r_flags[2];
    assign w_l = r_flags[1];
    assign w_c = r_flags[0];

    assign w_pc_inc = r_pc + ONE;

    // Always decoded against the registered flags, so a coincident flagWrite is not seen yet.
    always_comb begin
        w_cond = 1'b0;
        case (bus.flagOp)
            4'h0:    w_cond = w_z;
            4'h1:    w_cond = !w_z;
            4'h2:    w_cond = w_c;
            4'h3:    w_cond = !w_c;
            4'h4:    w_cond = w_l;
            4'h5:    w_cond = !w_l;
            4'h6:    w_cond = w_n;
            4'h7:    w_cond = !w_n;
            4'h8:    w_cond = w_f;
            4'h9:    w_cond = !w_f;
            4'hA:    w_cond = !w_l && !w_z;
            4'hB:    w_cond = w_l || w_z;
            4'hC:    w_cond = !w_n && !w_z;
            4'hD:    w_cond = w_n || w_z;
            default: w_cond = 1'b1;
        endcase
    end

    assign w_taken = (bus.pcJump || bus.pcBranch) && w_cond;

    always_comb begin
        w_pc_next = r_pc;
        if (bus.pcJump) begin
            w_pc_next = w_cond ? bus.jumpTarget : w_pc_inc;
        end else if (bus.pcBranch) begin
            w_pc_next = w_cond ? (r_pc + bus.immediate) : w_pc_inc;
        end else if (bus.pcAdd) begin
            w_pc_next = w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_flags    <= 5'b0;
            r_redirect <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_redirect <= w_taken;
            if (bus.flagWrite) begin
                r_flags <= bus.aluFlags;
            end
        end
    end

`ifdef PC_TAKEN_COUNT_EN
    logic [15:0] r_taken_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_taken_cnt <= 16'h0000;
        end else if (w_taken && (r_taken_cnt != 16'hFFFF)) begin
            r_taken_cnt <= r_taken_cnt + 16'd1;
        end
    end

    assign bus.takenCount = r_taken_cnt;
`else
    assign bus.takenCount = 16'h0000;
`endif

    assign bus.pc       = r_pc;
    assign bus.pcLink   = w_pc_inc;
    assign bus.flags    = r_flags;
    assign bus.condMet  = w_cond;
    assign bus.redirect = r_redirect;
endmodule

// File: doc/pc_flag_unit.md
Name: pc_flag_unit

Overview:
- Program-counter and processor-status stage directly downstream of the multicycle controller.
- Consumes the controller's pcAdd, pcJump and pcBranch strobes, flagOp, and sign-extended immediate, plus the register-file A-port value and the ALU's flag outputs.
- Owns the PC register and the 5-bit flag register (N,Z,F,L,C) and evaluates the branch/jump condition codes.
- Drives the fetch address to instruction memory and the link value (pc+1) to the register-file write bus.

Parameters:
WIDTH, 16, datapath and PC width
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
pcAdd  input  1  advance PC by 1
pcJump  input  1  conditional absolute jump to jumpTarget
pcBranch  input  1  conditional relative branch by immediate
flagOp  input  4  condition code selecting the jump/branch test
immediate  input  WIDTH  sign-extended branch displacement
jumpTarget  input  WIDTH  register A value, the absolute jump target
flagWrite  input  1  load aluFlags into the flag register
aluFlags  input  5  {N,Z,F,L,C} from the ALU
pc  output  WIDTH  current PC, the fetch address
pcLink  output  WIDTH  pc+1, the JAL link value
flags  output  5  registered {N,Z,F,L,C}
condMet  output  1  combinational result of flagOp against the registered flags
redirect  output  1  registered one-cycle pulse: previous edge loaded a non-sequential PC
takenCount  output  16  taken jump/branch counter (optional feature)

Behaviour:
- Reset (reset==0 at posedge clk):
  - pc<=RESET_PC; flags<=5'b0; redirect<=0; takenCount<=0.
  - Reset overrides every command in the same cycle, including a command mid-instruction.
- PC update priority per edge: pcJump > pcBranch > pcAdd > hold.
  - pcJump: pc<=condMet ? jumpTarget : pc+1.
  - pcBranch: pc<=condMet ? pc+immediate : pc+1.
  - pcAdd: pc<=pc+1.
  - No strobe: pc holds.
- Arithmetic is modulo 2^WIDTH; 16'hFFFF+1 wraps to 16'h0000. A negative immediate reaches lower addresses with wrap.
- pcLink = pc+1 (combinational, wraps). It is sampled by the register file during the JAL state, before the jump state.
- Flag register:
  - On flagWrite, flags<=aluFlags; otherwise flags hold.
  - Condition evaluation always uses the registered flags. If flagWrite coincides with a jump/branch, the old flags decide and the new flags take effect the next cycle.
- condMet decode of flagOp (Z=flags[3], F=flags[2], L=flags[1], C=flags[0], N=flags[4]):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L&!Z
  - B HS: L|Z
  - C LT: !N&!Z
  - D GE: N|Z
  - E UC: 1
  - F: 1 (JAL path, unconditional)
- redirect<=1 for one cycle after any edge where pcJump or pcBranch was taken (condMet=1); otherwise 0. An untaken branch does not pulse.
- No internal FSM beyond these registers. Strobes are level-sampled each edge, and the controller guarantees each strobe is high for exactly one state.

Optional Feature:
- Macro: PC_TAKEN_COUNT_EN.
- Defined: takenCount increments on every edge producing a redirect. It saturates at 16'hFFFF, clears on reset, and does not change on untaken branches.
- Undefined: no counter logic; takenCount is tied to 16'h0000.

Test Plan:
- Reset with RESET_PC=16'h0010, then 3 cycles of pcAdd -> pc=16'h0013, pcLink=16'h0014, flags=0, redirect=0.
- flagWrite with aluFlags=5'b01000 (Z), then pcBranch, flagOp=0, immediate=16'hFFFC at pc=16'h0020 -> pc=16'h001C; redirect pulses 1 cycle; takenCount=1 if enabled.
- Same branch with flagOp=1 (NE) -> pc=16'h0021, no redirect, takenCount unchanged.
- pc=16'hFFFF, pcAdd -> pc=16'h0000. pcBranch, immediate=16'h0002, flagOp=E -> pc=16'h0002.
- Same edge: flagWrite clears Z while pcJump, flagOp=0, jumpTarget=16'h1234 -> jump taken (old Z=1), pc=16'h1234, flags then 0.
- pcJump, pcBranch and pcAdd asserted together with flagOp=F and jumpTarget=16'h00AA -> pc=16'h00AA. Reset asserted in the same cycle instead -> pc=RESET_PC.
